alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters (req0 = main execute path, req1 = auxiliary address/flag-op path) using round-robin valid/ready arbitration.
- Holds the architectural status (flags) register, feeds it to the ALU, and commits the ALU status output.
- Holds MUL/DIV operands stable for a parameterised number of cycles so those ALU paths are timed as multicycle.
- Returns the registered result, flags and requester id on a response handshake.

Parameters:
- MUL_CYCLES, 2, EXEC cycles for an op with ALU_OP_MUL set (min 1).
- DIV_CYCLES, 8, EXEC cycles for a divide, i.e. none of ALU_OP_ADD/SUB/AND/OR/XOR/MUL set (min 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request valid (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle.
- reqN_cntl  in  14  ALU control word, same encoding as the ALU cntl input.
- reqN_opnd0, reqN_opnd1  in  32  operands.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  32  ALU result.
- rsp_status  out  6  flags after the op.
- rsp_err  out  1  divide by zero.
- alu_cntl  out  14  to ALU cntl.
- alu_opnd0, alu_opnd1  out  32  to ALU operands.
- alu_status_in  out  6  to ALU status_in; always equals flags.
- alu_status_out  in  6  from ALU.
- alu_result  in  32  from ALU.
- flags  out  6  architectural flags register.
- flags_ld  in  1  external flags load (POPF/SAHF path).
- flags_ld_val  in  6  value to load.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = 1 (so req0 wins first).
  - flags, issue registers, cycle counter, rsp_result, rsp_status, rsp_id and rsp_err are all 0.
  - rsp_valid = 0.
  - Reset asserted mid-op abandons the op; no response is produced for it.
- States:
  - IDLE: arbitration.
    - One valid requester: grant it.
    - Both valid: grant the requester != last_grant.
    - reqN_ready is combinational: state == IDLE and N granted. At most one ready per cycle.
    - On handshake: latch cntl/opnds/id into the issue registers, update last_grant, load cnt = LAT-1, go to EXEC.
    - LAT is 1 for ADD/SUB/AND/OR/XOR, MUL_CYCLES for MUL, DIV_CYCLES for divide. Decode priority matches the ALU: ADD > SUB > AND > OR > XOR > MUL > div.
  - EXEC: alu_cntl/alu_opnd0/alu_opnd1 are driven from the issue registers and held stable for all LAT cycles.
    - cnt decrements each cycle.
    - When cnt == 0: capture rsp_result = alu_result and rsp_status = alu_status_out, write flags <= alu_status_out, set rsp_valid = 1, go to HOLD.
  - HOLD: rsp_* held stable until rsp_ready. On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
    - No new grant in the same cycle.
    - Throughput is one op per LAT+2 cycles.
- Outside EXEC, alu_cntl and both ALU operands are driven to 0.
- Divide by zero (divide op with issue opnd1 == 0):
  - The ALU operands are forced to opnd1 = 1 so the divider is never fed 0.
  - At capture: rsp_result = 0, rsp_err = 1, rsp_status = flags (unchanged), flags not written. LAT is still DIV_CYCLES.
  - rsp_err = 0 for every other op.
- ALU_NO_WR is honoured by the ALU itself, so capture writes alu_status_out unconditionally. The flags therefore remain unchanged for no-write ops.
- flags_ld:
  - Takes effect only when state == IDLE; ignored in EXEC/HOLD.
  - If a grant happens in the same cycle, the load still applies, and the granted op sees the loaded flags in EXEC.
- A requester may drop valid before it is granted; there is no starvation beyond one op under continuous contention.

Test Plan:
- Reset, then req0 ADD opnd0=0xFFFFFFFF, opnd1=1 -> req0_ready the same cycle, rsp_valid 2 cycles later, rsp_result=0, rsp_status CF=1 ZF=1, flags updated, rsp_id=0.
- req0 and req1 valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; no cycle has both readys high.
- req1 divide 100/7 with DIV_CYCLES=8 -> alu_opnd* stable for 8 cycles, rsp_result=14, rsp_id=1; busy high 9 cycles before the response is consumed.
- Divide 5/0 with flags=0x3F beforehand -> rsp_err=1, rsp_result=0, rsp_status=0x3F, flags still 0x3F.
- rsp_ready held low 5 cycles during HOLD while req0_valid=1 -> rsp_* stable, req0_ready=0 until 1 cycle after the rsp handshake; flags_ld pulsed during HOLD is ignored, and flags_ld=0x01 in IDLE is loaded.
- rst_n asserted mid-EXEC of a MUL -> all outputs 0 immediately (asynchronously); after release no stale response appears, and the next grant goes to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin valid/ready front end for the shared combinational ALU.
// Owns the architectural flags and times MUL/DIV as multicycle paths.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [13:0] req0_cntl,
  input  logic [31:0] req0_opnd0,
  input  logic [31:0] req0_opnd1,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [13:0] req1_cntl,
  input  logic [31:0] req1_opnd0,
  input  logic [31:0] req1_opnd1,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [5:0]  rsp_status,
  output logic        rsp_err,

  output logic [13:0] alu_cntl,
  output logic [31:0] alu_opnd0,
  output logic [31:0] alu_opnd1,
  output logic [5:0]  alu_status_in,
  input  logic [5:0]  alu_status_out,
  input  logic [31:0] alu_result,

  output logic [5:0]  flags,
  input  logic        flags_ld,
  input  logic [5:0]  flags_ld_val,
  output logic        busy
);

  localparam int unsigned CNTL_W  = 14;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STAT_W  = 6;
  localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // ALU control word opcode bit positions
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_MUL = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic              id;
    logic [CNTL_W-1:0] cntl;
    logic [DATA_W-1:0] opnd0;
    logic [DATA_W-1:0] opnd1;
  } issue_t;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  issue_t            issue_q, issue_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] flags_q, flags_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [STAT_W-1:0] rsp_status_q, rsp_status_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant0_c, grant1_c;
  logic [CNTL_W-1:0] sel_cntl_c;
  logic              issue_div_c, issue_div0_c;

  // Exec cycles minus one; single-cycle ops outrank MUL, anything else is a divide
  function automatic logic [CNT_W-1:0] lat_m1(input logic [CNTL_W-1:0] c);
    if (c[OP_ADD] | c[OP_SUB] | c[OP_AND] | c[OP_OR] | c[OP_XOR]) return '0;
    if (c[OP_MUL]) return CNT_W'(MUL_CYCLES - 1);
    return CNT_W'(DIV_CYCLES - 1);
  endfunction

  // Both valid: the requester that did not win last time goes first
  assign grant0_c   = req0_valid & (~req1_valid | last_grant_q);
  assign grant1_c   = req1_valid & (~req0_valid | ~last_grant_q);
  assign sel_cntl_c = grant1_c ? req1_cntl : req0_cntl;

  assign issue_div_c  = ~(issue_q.cntl[OP_ADD] | issue_q.cntl[OP_SUB] | issue_q.cntl[OP_AND] |
                          issue_q.cntl[OP_OR]  | issue_q.cntl[OP_XOR] | issue_q.cntl[OP_MUL]);
  assign issue_div0_c = issue_div_c & (issue_q.opnd1 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    issue_d      = issue_q;
    cnt_d        = cnt_q;
    flags_d      = flags_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    alu_cntl     = '0;
    alu_opnd0    = '0;
    alu_opnd1    = '0;

    case (state_q)
      ST_IDLE: begin
        if (flags_ld) flags_d = flags_ld_val;
        if (grant0_c | grant1_c) begin
          req0_ready    = grant0_c;
          req1_ready    = grant1_c;
          issue_d.id    = grant1_c;
          issue_d.cntl  = sel_cntl_c;
          issue_d.opnd0 = grant1_c ? req1_opnd0 : req0_opnd0;
          issue_d.opnd1 = grant1_c ? req1_opnd1 : req0_opnd1;
          last_grant_d  = grant1_c;
          cnt_d         = lat_m1(sel_cntl_c);
          state_d       = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Divider is never fed a zero divisor; the result is discarded anyway
        alu_cntl  = issue_q.cntl;
        alu_opnd0 = issue_q.opnd0;
        alu_opnd1 = issue_div0_c ? DATA_W'(1) : issue_q.opnd1;
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = issue_q.id;
          rsp_err_d   = issue_div0_c;
          if (issue_div0_c) begin
            rsp_result_d = '0;
            rsp_status_d = flags_q;
          end else begin
            rsp_result_d = alu_result;
            rsp_status_d = alu_status_out;
            flags_d      = alu_status_out;
          end
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      issue_q      <= '0;
      cnt_q        <= '0;
      flags_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      issue_q      <= issue_d;
      cnt_q        <= cnt_d;
      flags_q      <= flags_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_err       = rsp_err_q;
  assign flags         = flags_q;
  assign alu_status_in = flags_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: drives a behavioural ALU, keeps a transaction-level
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_alu_arbiter;

  localparam int MUL_C = 2;
  localparam int DIV_C = 8;

  localparam logic [13:0] C_ADD   = 14'h0001;
  localparam logic [13:0] C_XOR   = 14'h0010;
  localparam logic [13:0] C_MUL   = 14'h0020;
  localparam logic [13:0] C_DIV   = 14'h0000;
  localparam logic [13:0] C_NOWR  = 14'h2000;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [13:0] req0_cntl, req1_cntl;
  logic [31:0] req0_opnd0, req0_opnd1, req1_opnd0, req1_opnd1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [5:0]  rsp_status;
  logic [13:0] alu_cntl;
  logic [31:0] alu_opnd0, alu_opnd1, alu_result;
  logic [5:0]  alu_status_in, alu_status_out;
  logic [5:0]  flags, flags_ld_val;
  logic        flags_ld, busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntl(req0_cntl),
    .req0_opnd0(req0_opnd0), .req0_opnd1(req0_opnd1),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntl(req1_cntl),
    .req1_opnd0(req1_opnd0), .req1_opnd1(req1_opnd1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_status(rsp_status), .rsp_err(rsp_err),
    .alu_cntl(alu_cntl), .alu_opnd0(alu_opnd0), .alu_opnd1(alu_opnd1),
    .alu_status_in(alu_status_in), .alu_status_out(alu_status_out),
    .alu_result(alu_result), .flags(flags), .flags_ld(flags_ld),
    .flags_ld_val(flags_ld_val), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags: CF=0 ZF=1 SF=2 OF=3; bits 5:4 pass through; NO_WR (bit 13) keeps status_in
  function automatic logic [37:0] alu_fn(input logic [13:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [5:0] s);
    logic [32:0] w;
    logic [31:0] r;
    logic        cf, of;
    w = '0; r = '0; cf = 1'b0; of = 1'b0;
    if (c[0]) begin
      w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cf = w[32];
      of = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (c[1]) begin
      w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cf = w[32];
      of = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (c[2]) r = a & b;
    else if (c[3]) r = a | b;
    else if (c[4]) r = a ^ b;
    else if (c[5]) r = a * b;
    else r = (b == 32'd0) ? 32'd0 : a / b;
    if (c[13]) return {s, r};
    return {s[5:4], of, r[31], (r == 32'd0), cf, r};
  endfunction

  assign {alu_status_out, alu_result} = alu_fn(alu_cntl, alu_opnd0, alu_opnd1, alu_status_in);

  function automatic int lat(input logic [13:0] c);
    if (c[4:0] != 5'd0) return 1;
    if (c[5]) return MUL_C;
    return DIV_C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one op in flight, response computed when its latency expires
  int          m_left;
  logic        m_pend, m_last, m_id, m_rid, m_e;
  logic [13:0] m_c;
  logic [31:0] m_a, m_b, m_r;
  logic [5:0]  m_flags, m_s;

  always @(negedge clk) begin : model_cmp
    logic idle, eg0, eg1, ex, div0;
    if (!rst_n) begin
      m_left = 0; m_pend = 1'b0; m_last = 1'b1; m_flags = '0; m_r = '0; m_s = '0;
      m_e = 1'b0; m_rid = 1'b0; m_c = '0; m_a = '0; m_b = '0; m_id = 1'b0;
    end
    idle = (m_left == 0) && !m_pend;
    eg0  = idle && req0_valid && (!req1_valid || m_last);
    eg1  = idle && req1_valid && (!req0_valid || !m_last);
    ex   = (m_left > 0);
    div0 = (m_c[5:0] == 6'd0) && (m_b == 32'd0);
    chk("m_ready0", 32'(req0_ready), 32'(eg0));
    chk("m_ready1", 32'(req1_ready), 32'(eg1));
    chk("m_busy", 32'(busy), 32'(!idle));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_pend));
    chk("m_flags", 32'(flags), 32'(m_flags));
    chk("m_status_in", 32'(alu_status_in), 32'(m_flags));
    chk("m_alu_cntl", 32'(alu_cntl), ex ? 32'(m_c) : 32'd0);
    chk("m_alu_opnd0", alu_opnd0, ex ? m_a : 32'd0);
    chk("m_alu_opnd1", alu_opnd1, ex ? (div0 ? 32'd1 : m_b) : 32'd0);
    chk("m_rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("m_rsp_result", rsp_result, m_r);
    chk("m_rsp_status", 32'(rsp_status), 32'(m_s));
    chk("m_rsp_err", 32'(rsp_err), 32'(m_e));
    if (rst_n) begin
      if (idle) begin
        if (flags_ld) m_flags = flags_ld_val;
        if (eg0 || eg1) begin
          m_c    = eg1 ? req1_cntl  : req0_cntl;
          m_a    = eg1 ? req1_opnd0 : req0_opnd0;
          m_b    = eg1 ? req1_opnd1 : req0_opnd1;
          m_id   = eg1;
          m_last = eg1;
          m_left = lat(m_c);
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (div0) begin
            m_r = '0; m_s = m_flags; m_e = 1'b1;
          end else begin
            {m_s, m_r} = alu_fn(m_c, m_a, m_b, m_flags);
            m_e = 1'b0;
            m_flags = m_s;
          end
          m_rid  = m_id;
          m_pend = 1'b1;
        end
      end else if (rsp_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  logic [31:0] first_op0, first_op1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic id, input logic [13:0] c, input logic [31:0] a,
                       input logic [31:0] b, output int n);
    logic got;
    if (id) begin req1_cntl = c; req1_opnd0 = a; req1_opnd1 = b; req1_valid = 1'b1; end
    else    begin req0_cntl = c; req0_opnd0 = a; req0_opnd1 = b; req0_valid = 1'b1; end
    n = 0;
    do begin
      @(negedge clk); n++;
      got = id ? req1_ready : req0_ready;
    end while (!got && n < 50);
    chk("grant_wait", 32'(got), 32'd1);
    step();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin first_op0 = alu_opnd0; first_op1 = alu_opnd1; end
    end while (!rsp_valid && cyc < 50);
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 50);
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n, cyc;
    int seq[4];
    rst_n = 1'b1; rsp_ready = 1'b1; flags_ld = 1'b0; flags_ld_val = '0;
    req0_valid = 1'b0; req0_cntl = '0; req0_opnd0 = '0; req0_opnd1 = '0;
    req1_valid = 1'b0; req1_cntl = '0; req1_opnd0 = '0; req1_opnd1 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();

    // ADD wraps to zero: carry and zero set
    issue(1'b0, C_ADD, 32'hFFFF_FFFF, 32'd1, n);
    chk("t1_ready_same_cycle", 32'(n), 32'd1);
    wait_rsp(cyc);
    chk("t1_latency", 32'(cyc), 32'd2);
    chk("t1_result", rsp_result, 32'd0);
    chk("t1_status", 32'(rsp_status), 32'h03);
    chk("t1_flags", 32'(flags), 32'h03);
    chk("t1_id", 32'(rsp_id), 32'd0);
    wait_idle();
    step();

    // req1 divide 100/7 over 8 exec cycles
    issue(1'b1, C_DIV, 32'd100, 32'd7, n);
    wait_rsp(cyc);
    chk("t3_busy_cycles", 32'(cyc), 32'd9);
    chk("t3_opnd0", first_op0, 32'd100);
    chk("t3_opnd1", first_op1, 32'd7);
    chk("t3_result", rsp_result, 32'd14);
    chk("t3_id", 32'(rsp_id), 32'd1);
    chk("t3_status", 32'(rsp_status), 32'h00);
    @(negedge clk);
    chk("t3_busy_after", 32'(busy), 32'd0);
    step();

    // Continuous contention alternates grants
    req0_cntl = C_ADD; req0_opnd0 = 32'd10; req0_opnd1 = 32'd1;
    req1_cntl = C_ADD; req1_opnd0 = 32'd20; req1_opnd1 = 32'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      chk("t2_one_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_ready | req1_ready) begin seq[n] = int'(req1_ready); n++; end
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_grants", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 32'(seq[i]), 32'(i % 2));
    wait_idle();
    step();

    // Divide by zero keeps the loaded flags
    flags_ld = 1'b1; flags_ld_val = 6'h3F;
    step();
    flags_ld = 1'b0;
    @(negedge clk);
    chk("t4_flags_loaded", 32'(flags), 32'h3F);
    step();
    issue(1'b0, C_DIV, 32'd5, 32'd0, n);
    wait_rsp(cyc);
    chk("t4_latency", 32'(cyc), 32'd9);
    chk("t4_opnd1_forced", first_op1, 32'd1);
    chk("t4_err", 32'(rsp_err), 32'd1);
    chk("t4_result", rsp_result, 32'd0);
    chk("t4_status", 32'(rsp_status), 32'h3F);
    chk("t4_flags", 32'(flags), 32'h3F);
    wait_idle();
    step();

    // Response back-pressure with a waiting requester and flag loads
    rsp_ready = 1'b0;
    issue(1'b0, C_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, n);
    req0_cntl = C_ADD | C_NOWR; req0_opnd0 = 32'd7; req0_opnd1 = 32'd9; req0_valid = 1'b1;
    wait_rsp(cyc);
    chk("t5_result", rsp_result, 32'hFFFF_FFFF);
    chk("t5_status", 32'(rsp_status), 32'h34);
    chk("t5_err", 32'(rsp_err), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      flags_ld = (i == 1); flags_ld_val = 6'h2A;
      @(negedge clk);
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_result", rsp_result, 32'hFFFF_FFFF);
      chk("t5_hold_ready0", 32'(req0_ready), 32'd0);
    end
    step();
    flags_ld = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_hs_ready0", 32'(req0_ready), 32'd0);
    chk("t5_ld_ignored", 32'(flags), 32'h34);
    step();
    flags_ld = 1'b1; flags_ld_val = 6'h01;
    @(negedge clk);
    chk("t5_idle_ready0", 32'(req0_ready), 32'd1);
    step();
    flags_ld = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("t5_ld_applied", 32'(flags), 32'h01);
    wait_rsp(cyc);
    chk("t5b_result", rsp_result, 32'd16);
    chk("t5b_status", 32'(rsp_status), 32'h01);
    chk("t5b_flags", 32'(flags), 32'h01);
    wait_idle();
    step();

    // Asynchronous reset in the middle of a MUL
    issue(1'b0, C_MUL, 32'd3, 32'd4, n);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_alu_cntl", 32'(alu_cntl), 32'd0);
    chk("t6_alu_opnd0", alu_opnd0, 32'd0);
    chk("t6_alu_opnd1", alu_opnd1, 32'd0);
    chk("t6_flags", 32'(flags), 32'd0);
    chk("t6_rsp_result", rsp_result, 32'd0);
    chk("t6_rsp_status", 32'(rsp_status), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(rsp_valid), 32'd0);
    end
    step();
    req0_cntl = C_ADD; req0_opnd0 = 32'd1; req0_opnd1 = 32'd2; req0_valid = 1'b1;
    req1_cntl = C_ADD; req1_opnd0 = 32'd3; req1_opnd1 = 32'd4; req1_valid = 1'b1;
    @(negedge clk);
    chk("t6_first_ready0", 32'(req0_ready), 32'd1);
    chk("t6_first_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(cyc);
    chk("t6_id", 32'(rsp_id), 32'd0);
    chk("t6_result", rsp_result, 32'd3);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
